// File: rtl/sgd_param_update.sv
// Holds one layer's W/b and applies a plain SGD step W -= LR*dw, b -= LR*db,
// one element per clock through a single shared multiplier.
module sgd_param_update #(
   parameter int M    = 5,
   parameter int N    = 3,
   parameter int FRAC = 12,
   parameter int LR   = 41,
   parameter int DW   = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          load,
   input  logic [M-1:0][N-1:0][DW-1:0]   W_in,
   input  logic [M-1:0][DW-1:0]          b_in,
   input  logic                          start,
   input  logic [M-1:0][N-1:0][DW-1:0]   dw,
   input  logic [M-1:0][DW-1:0]          db,
   output logic [M-1:0][N-1:0][DW-1:0]   W,
   output logic [M-1:0][DW-1:0]          b,
   output logic                          busy,
   output logic                          done
);

   localparam int IW = (M > 1) ? $clog2(M) : 1;
   localparam int JW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] I_LAST = IW'(M-1);
   localparam logic [JW-1:0] J_LAST = JW'(N-1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_UPD_W = 2'd1;
   localparam logic [1:0] S_UPD_B = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic signed [DW-1:0]   LR_D  = DW'(LR);
   localparam logic signed [2*DW:0]   MAX_V = {{(DW+2){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [2*DW:0]   MIN_V = {{(DW+2){1'b1}}, {(DW-1){1'b0}}};

   logic [1:0]                    state;
   logic [IW-1:0]                 i;
   logic [JW-1:0]                 j;
   logic [M-1:0][N-1:0][DW-1:0]   dw_sh;
   logic [M-1:0][DW-1:0]          db_sh;

   logic signed [DW-1:0]   g, param;
   logic signed [2*DW-1:0] prod, shifted;
   logic signed [2*DW:0]   diff;
   logic [DW-1:0]          upd;

   // One datapath serves both phases; the operand mux picks the current element.
   always_comb begin
      g     = '0;
      param = '0;
      if (state == S_UPD_B) begin
         g     = db_sh[i];
         param = b[i];
      end else begin
         g     = dw_sh[i][j];
         param = W[i][j];
      end
      prod    = LR_D * g;
      shifted = prod >>> FRAC;
      diff    = $signed({{(DW+1){param[DW-1]}}, param}) - $signed({shifted[2*DW-1], shifted});
      if (diff > MAX_V)
         upd = MAX_V[DW-1:0];
      else if (diff < MIN_V)
         upd = MIN_V[DW-1:0];
      else
         upd = diff[DW-1:0];
   end

   assign busy = (state == S_UPD_W) || (state == S_UPD_B);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         i     <= '0;
         j     <= '0;
         W     <= '0;
         b     <= '0;
         dw_sh <= '0;
         db_sh <= '0;
         done  <= 1'b0;
      end else begin
         // done is registered off the DONE state, so it lands one edge after it
         done <= (state == S_DONE);
         case (state)
            S_IDLE: begin
               if (load) begin
                  W <= W_in;
                  b <= b_in;
               end else if (start) begin
                  dw_sh <= dw;
                  db_sh <= db;
                  i     <= '0;
                  j     <= '0;
                  state <= S_UPD_W;
               end
            end
            S_UPD_W: begin
               W[i][j] <= upd;
               if (j == J_LAST) begin
                  j <= '0;
                  if (i == I_LAST) begin
                     i     <= '0;
                     state <= S_UPD_B;
                  end else begin
                     i <= i + 1'b1;
                  end
               end else begin
                  j <= j + 1'b1;
               end
            end
            S_UPD_B: begin
               b[i] <= upd;
               if (i == I_LAST) begin
                  i     <= '0;
                  state <= S_DONE;
               end else begin
                  i <= i + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
